// File: rtl/ov7670_pkg.sv
// ov7670_pkg: shared types and constants for the OV7670 capture path.
package ov7670_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_FRAME, FRAME} cap_state_t;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;
  localparam int PIX_W = R_W + G_W + B_W;
  localparam int BYTES_RAW = 1;
  localparam int BYTES_RGB565 = 2;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchronizer with registered rise/fall strobes.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      chain <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= STAGES'({chain, din});
      level <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~level;
      fall  <= ~chain[STAGES-1] & level;
    end
  end
endmodule

// File: rtl/ov7670_pixel_capture.sv
// ov7670_pixel_capture: oversampled DVP capture producing coordinate-tagged pixels.
module ov7670_pixel_capture
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int BYTES_PER_PIXEL = BYTES_RAW,
  parameter int SYNC_STAGES = 2,
  localparam int XW = $clog2(H_ACTIVE + 1),
  localparam int YW = $clog2(V_ACTIVE + 1)
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             enable,
  input  logic             PCLK,
  input  logic             HREF,
  input  logic             VSYNC,
  input  logic [7:0]       D,
  output logic             pix_valid,
  output logic [PIX_W-1:0] pix_data,
  output logic [XW-1:0]    pix_x,
  output logic [YW-1:0]    pix_y,
  output logic [1:0]       bayer_phase,
  output logic             frame_start,
  output logic             frame_done,
  output logic [7:0]       frame_cnt,
  output logic             geom_err
);
  localparam logic [XW-1:0] H_MAX = XW'(H_ACTIVE);
  localparam logic [YW-1:0] V_MAX = YW'(V_ACTIVE);
  localparam bit RGB = BYTES_PER_PIXEL == BYTES_RGB565;
  logic pclk_rise, pclk_level_unused, pclk_fall_unused;
  logic href_level, href_fall, href_rise_unused;
  logic vs_rise, vs_fall, vs_level_unused;
  logic [7:0] d_chain [SYNC_STAGES];
  logic [7:0] d_q;
  sync_edge #(.STAGES(SYNC_STAGES)) u_pclk (
    .clk(clk), .reset_(reset_), .din(PCLK),
    .level(pclk_level_unused), .rise(pclk_rise), .fall(pclk_fall_unused)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_href (
    .clk(clk), .reset_(reset_), .din(HREF),
    .level(href_level), .rise(href_rise_unused), .fall(href_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_vsync (
    .clk(clk), .reset_(reset_), .din(VSYNC),
    .level(vs_level_unused), .rise(vs_rise), .fall(vs_fall)
  );
  // d_q lines the data bus up with the registered strobes
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < SYNC_STAGES; i++) d_chain[i] <= '0;
      d_q <= '0;
    end else begin
      d_chain[0] <= D;
      for (int i = 1; i < SYNC_STAGES; i++) d_chain[i] <= d_chain[i-1];
      d_q <= d_chain[SYNC_STAGES-1];
    end
  end
  cap_state_t state, state_n;
  logic [XW-1:0] x, x_n, pix_x_n;
  logic [YW-1:0] y, y_n, pix_y_n;
  logic bp, bp_n;
  logic [7:0] hi, hi_n, frame_cnt_n;
  logic [PIX_W-1:0] pix_data_n;
  logic [1:0] bayer_phase_n;
  logic pix_valid_n, frame_start_n, frame_done_n, geom_err_n;
  // a strobe that coincides with HREF falling still belongs to the line
  logic byte_ok;
  assign byte_ok = pclk_rise & (href_level | href_fall);
  always_comb begin
    state_n = state;
    x_n = x;
    y_n = y;
    bp_n = bp;
    hi_n = hi;
    geom_err_n = geom_err;
    frame_cnt_n = frame_cnt;
    pix_valid_n = 1'b0;
    pix_data_n = pix_data;
    pix_x_n = pix_x;
    pix_y_n = pix_y;
    bayer_phase_n = bayer_phase;
    frame_start_n = 1'b0;
    frame_done_n = 1'b0;
    if (state == IDLE) begin
      state_n = enable ? WAIT_FRAME : IDLE;
    end else if (state == WAIT_FRAME) begin
      if (vs_fall) begin
        state_n = FRAME;
        frame_start_n = 1'b1;
        x_n = '0;
        y_n = '0;
        bp_n = 1'b0;
      end
    end else if (vs_rise) begin
      frame_done_n = 1'b1;
      frame_cnt_n = frame_cnt + 8'd1;
      geom_err_n = geom_err | (y != V_MAX);
      state_n = enable ? WAIT_FRAME : IDLE;
    end else begin
      if (byte_ok && RGB && !bp) begin
        hi_n = d_q;
        bp_n = 1'b1;
      end else if (byte_ok) begin
        bp_n = 1'b0;
        pix_valid_n = (x != H_MAX) && (y != V_MAX);
        pix_data_n = pix_valid_n ? (RGB ? {hi, d_q} : {8'h00, d_q}) : pix_data;
        pix_x_n = pix_valid_n ? x : pix_x;
        pix_y_n = pix_valid_n ? y : pix_y;
        bayer_phase_n = pix_valid_n ? {y[0], x[0]} : bayer_phase;
        x_n = (x == H_MAX) ? x : x + 1'b1;
        geom_err_n = geom_err | (x == H_MAX);
      end
      // saturated counters cannot see overruns, so they are flagged as they happen
      if (href_fall) begin
        geom_err_n = geom_err_n | (x_n != H_MAX) | (y == V_MAX);
        x_n = '0;
        bp_n = 1'b0;
        y_n = (y == V_MAX) ? y : y + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      bp <= 1'b0;
      hi <= '0;
      geom_err <= 1'b0;
      frame_cnt <= '0;
      pix_valid <= 1'b0;
      pix_data <= '0;
      pix_x <= '0;
      pix_y <= '0;
      bayer_phase <= '0;
      frame_start <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      x <= x_n;
      y <= y_n;
      bp <= bp_n;
      hi <= hi_n;
      geom_err <= geom_err_n;
      frame_cnt <= frame_cnt_n;
      pix_valid <= pix_valid_n;
      pix_data <= pix_data_n;
      pix_x <= pix_x_n;
      pix_y <= pix_y_n;
      bayer_phase <= bayer_phase_n;
      frame_start <= frame_start_n;
      frame_done <= frame_done_n;
    end
  end
endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// tb_ov7670_pixel_capture: raw and RGB565 instances on one camera bus, checked against a frame-level model.
module tb_ov7670_pixel_capture;
  localparam int H = 4;
  localparam int V = 2;
  localparam int S = 2;
  localparam int XW = $clog2(H + 1);
  localparam int YW = $clog2(V + 1);
  typedef struct packed {
    logic [15:0] data;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [1:0] ph;
  } pix_t;
  typedef struct {
    int nl;
    int len;
    int r_pix;
    int r_geom;
    int g_pix;
    int g_geom;
  } vec_t;
  logic clk = 0, reset_ = 0, enable = 0, PCLK = 0, HREF = 0, VSYNC = 1;
  logic [7:0] D = 0;
  logic r_valid, r_fs, r_fd, r_geom, g_valid, g_fs, g_fd, g_geom;
  logic [15:0] r_data, g_data;
  logic [XW-1:0] r_x, g_x;
  logic [YW-1:0] r_y, g_y;
  logic [1:0] r_ph, g_ph;
  logic [7:0] r_cnt, g_cnt;
  always #5 clk = ~clk;
  ov7670_pixel_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .BYTES_PER_PIXEL(1), .SYNC_STAGES(S)) dut_raw (
    .clk(clk), .reset_(reset_), .enable(enable), .PCLK(PCLK), .HREF(HREF), .VSYNC(VSYNC), .D(D),
    .pix_valid(r_valid), .pix_data(r_data), .pix_x(r_x), .pix_y(r_y), .bayer_phase(r_ph),
    .frame_start(r_fs), .frame_done(r_fd), .frame_cnt(r_cnt), .geom_err(r_geom)
  );
  ov7670_pixel_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .BYTES_PER_PIXEL(2), .SYNC_STAGES(S)) dut_rgb (
    .clk(clk), .reset_(reset_), .enable(enable), .PCLK(PCLK), .HREF(HREF), .VSYNC(VSYNC), .D(D),
    .pix_valid(g_valid), .pix_data(g_data), .pix_x(g_x), .pix_y(g_y), .bayer_phase(g_ph),
    .frame_start(g_fs), .frame_done(g_fd), .frame_cnt(g_cnt), .geom_err(g_geom)
  );
  int cyc = 0, rise_cyc = 0, last_lat = 0;
  int fs_r = 0, fd_r = 0, fs_g = 0, fd_g = 0;
  int clr_tok = 0, seen_tok = 0;
  pix_t got_r[$], got_g[$], exp_r[$], exp_g[$];
  int lens[$];
  logic [7:0] byte_q[$];
  bit geom_r_m, geom_g_m;
  int cnt_m;
  int n_cmp = 0, n_fail = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (clr_tok != seen_tok) begin
      got_r.delete();
      got_g.delete();
      fs_r = 0; fd_r = 0; fs_g = 0; fd_g = 0;
      seen_tok = clr_tok;
    end
    if (r_valid) begin
      got_r.push_back({r_data, r_x, r_y, r_ph});
      last_lat = cyc - rise_cyc;
    end
    if (g_valid) got_g.push_back({g_data, g_x, g_y, g_ph});
    fs_r += int'(r_fs); fd_r += int'(r_fd);
    fs_g += int'(g_fs); fd_g += int'(g_fd);
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic clear_obs();
    clr_tok++;
    repeat (2) @(negedge clk);
  endtask
  task automatic do_reset();
    reset_ = 0;
    repeat (2) @(negedge clk);
    reset_ = 1;
    @(negedge clk);
    geom_r_m = 0; geom_g_m = 0; cnt_m = 0;
  endtask
  task automatic check_zero();
    chk("rst_raw_data", 32'(r_data), 0);
    chk("rst_raw_ctl", 32'({r_valid, r_x, r_y, r_ph, r_fs, r_fd, r_cnt, r_geom}), 0);
    chk("rst_rgb_data", 32'(g_data), 0);
    chk("rst_rgb_ctl", 32'({g_valid, g_x, g_y, g_ph, g_fs, g_fd, g_cnt, g_geom}), 0);
  endtask
  task automatic build_frame(input int nl, input int len);
    lens.delete();
    byte_q.delete();
    for (int l = 0; l < nl; l++) begin
      lens.push_back(len);
      for (int b = 0; b < len; b++) byte_q.push_back(8'($urandom));
    end
  endtask
  // expected pixels derived from line lengths and byte stream, not from counters
  task automatic model_frame();
    int k = 0;
    pix_t p;
    exp_r.delete();
    exp_g.delete();
    for (int l = 0; l < lens.size(); l++) begin
      for (int b = 0; b < lens[l]; b++) begin
        int q = b / 2;
        if (b < H && l < V) begin
          p = {8'h00, byte_q[k+b], XW'(b), YW'(l), l[0], b[0]};
          exp_r.push_back(p);
        end
        if (b % 2 == 1 && q < H && l < V) begin
          p = {byte_q[k+b-1], byte_q[k+b], XW'(q), YW'(l), l[0], q[0]};
          exp_g.push_back(p);
        end
      end
      geom_r_m |= lens[l] != H;
      geom_g_m |= lens[l] / 2 != H;
      k += lens[l];
    end
    geom_r_m |= lens.size() != V;
    geom_g_m |= lens.size() != V;
    cnt_m++;
  endtask
  task automatic drive_frame(input bit drop_en, input int rst_line);
    int k = 0;
    VSYNC = 1;
    repeat (16) @(negedge clk);
    VSYNC = 0;
    repeat (16) @(negedge clk);
    for (int l = 0; l < lens.size(); l++) begin
      if (drop_en && l == 0) enable = 0;
      HREF = 1;
      for (int b = 0; b < lens[l]; b++) begin
        PCLK = 0;
        D = byte_q[k];
        k++;
        repeat (4) @(negedge clk);
        PCLK = 1;
        rise_cyc = cyc;
        repeat (4) @(negedge clk);
        if (l == rst_line && b == 1) begin
          reset_ = 0;
          #1 check_zero();
          @(negedge clk);
          reset_ = 1;
        end
      end
      PCLK = 0;
      HREF = 0;
      repeat (12) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    VSYNC = 1;
    repeat (16) @(negedge clk);
  endtask
  task automatic cmp_frame(input string tag);
    chk({tag, "_raw_n"}, got_r.size(), exp_r.size());
    for (int i = 0; i < got_r.size() && i < exp_r.size(); i++) chk({tag, "_raw_pix"}, 32'(got_r[i]), 32'(exp_r[i]));
    chk({tag, "_rgb_n"}, got_g.size(), exp_g.size());
    for (int i = 0; i < got_g.size() && i < exp_g.size(); i++) chk({tag, "_rgb_pix"}, 32'(got_g[i]), 32'(exp_g[i]));
  endtask
  task automatic run_frame(input string tag);
    model_frame();
    clear_obs();
    drive_frame(0, -1);
    cmp_frame(tag);
  endtask
  vec_t vecs[6];
  logic [1:0] ph_tab[8];
  int len_opts[6];
  pix_t p0;
  initial begin
    vecs[0] = '{2, 4, 8, 0, 4, 1};
    vecs[1] = '{2, 8, 8, 1, 8, 0};
    vecs[2] = '{2, 3, 6, 1, 2, 1};
    vecs[3] = '{3, 4, 8, 1, 4, 1};
    vecs[4] = '{1, 8, 4, 1, 4, 1};
    vecs[5] = '{2, 6, 8, 1, 6, 1};
    ph_tab = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3};
    len_opts = '{3, 4, 4, 5, 8, 8};
    repeat (3) @(negedge clk);
    check_zero();
    reset_ = 1;
    @(negedge clk);
    for (int v = 0; v < 6; v++) begin
      do_reset();
      enable = 1;
      build_frame(vecs[v].nl, vecs[v].len);
      run_frame("vec");
      chk("vec_raw_count", got_r.size(), vecs[v].r_pix);
      chk("vec_raw_geom", 32'(r_geom), vecs[v].r_geom);
      chk("vec_rgb_count", got_g.size(), vecs[v].g_pix);
      chk("vec_rgb_geom", 32'(g_geom), vecs[v].g_geom);
      chk("vec_fs_fd", {fs_r[15:0], fd_r[15:0]}, {16'd1, 16'd1});
      chk("vec_frame_cnt", 32'({r_cnt, g_cnt}), 32'({8'd1, 8'd1}));
    end
    do_reset();
    enable = 1;
    build_frame(2, 4);
    for (int i = 0; i < 8; i++) byte_q[i] = 8'(16 + i);
    run_frame("raw4x2");
    chk("raw4x2_n", got_r.size(), 8);
    for (int i = 0; i < got_r.size() && i < 8; i++) begin
      p0 = {16'(16 + i), XW'(i % 4), YW'(i / 4), ph_tab[i]};
      chk("raw4x2_pix", 32'(got_r[i]), 32'(p0));
    end
    chk("raw4x2_latency", last_lat, S + 2);
    chk("raw4x2_frame", {fs_r[7:0], fd_r[7:0], r_cnt, 7'd0, r_geom}, {8'd1, 8'd1, 8'd1, 8'd0});
    do_reset();
    build_frame(2, 4);
    byte_q[0] = 8'hF8; byte_q[1] = 8'h00; byte_q[2] = 8'h07; byte_q[3] = 8'hE0;
    run_frame("rgb565");
    chk("rgb565_n", got_g.size(), 4);
    if (got_g.size() >= 2) begin
      chk("rgb565_px0", {got_g[0].data, 13'(got_g[0].x)}, {16'hF800, 13'd0});
      chk("rgb565_px1", {got_g[1].data, 13'(got_g[1].x)}, {16'h07E0, 13'd1});
    end
    do_reset();
    build_frame(2, 4);
    lens[0] = 3;
    void'(byte_q.pop_back());
    run_frame("short");
    chk("short_geom", 32'(r_geom), 1);
    build_frame(2, 4);
    run_frame("after_short");
    chk("after_short_n", got_r.size(), 8);
    chk("after_short_cnt", 32'(r_cnt), 2);
    chk("after_short_fs", fs_r, 1);
    do_reset();
    build_frame(2, 4);
    model_frame();
    clear_obs();
    drive_frame(1, -1);
    cmp_frame("en_drop");
    chk("en_drop_fd", fd_r, 1);
    chk("en_drop_cnt", 32'(r_cnt), 1);
    build_frame(2, 4);
    clear_obs();
    drive_frame(0, -1);
    chk("idle_fs", fs_r, 0);
    chk("idle_pix", got_r.size(), 0);
    chk("idle_cnt", 32'(r_cnt), 1);
    enable = 1;
    build_frame(2, 4);
    clear_obs();
    drive_frame(0, 1);
    chk("rst_mid_fd", fd_r, 0);
    chk("rst_mid_cnt", 32'(r_cnt), 0);
    geom_r_m = 0; geom_g_m = 0; cnt_m = 0;
    build_frame(2, 4);
    run_frame("after_rst");
    chk("after_rst_frame", {fs_r[7:0], fd_r[7:0], r_cnt, 7'd0, r_geom}, {8'd1, 8'd1, 8'd1, 8'd0});
    do_reset();
    enable = 1;
    for (int f = 0; f < 8; f++) begin
      int nl = $urandom_range(1, 3);
      lens.delete();
      byte_q.delete();
      for (int l = 0; l < nl; l++) begin
        lens.push_back(len_opts[$urandom_range(0, 5)]);
        for (int b = 0; b < lens[l]; b++) byte_q.push_back(8'($urandom));
      end
      run_frame("rand");
      chk("rand_raw_geom", 32'(r_geom), 32'(geom_r_m));
      chk("rand_rgb_geom", 32'(g_geom), 32'(geom_g_m));
      chk("rand_cnt", 32'({r_cnt, g_cnt}), 32'({8'(cnt_m), 8'(cnt_m)}));
      chk("rand_fs_fd", {fs_r[7:0], fd_r[7:0], fs_g[7:0], fd_g[7:0]}, 32'h01010101);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
